spi_ram_ctrl: RTL and testbench

SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

---
 rtl/spi_ram_ctrl.sv | 168 ++++++++++++++++
 tb/tb_spi_ram_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// SPI command decoder driving a simple single-port RAM: address set, write, and read with response handshake.
// Optional build macro SPI_RAM_CTRL_AUTOINC_EN: post-increment wr_addr/rd_addr after each RAM access.
module spi_ram_ctrl #(
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 cmd_drop
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] RD_REQ  = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  logic [2:0]           r_state;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic [ADDR_SIZE-1:0] r_mem_addr;
  logic [7:0]           r_mem_wdata;
  logic                 r_mem_we;
  logic                 r_mem_re;
  logic [7:0]           r_tx_data;
  logic                 r_tx_valid;
  logic                 r_busy;
  logic                 r_cmd_drop;

  logic [2:0]           w_state_nxt;
  logic [ADDR_SIZE-1:0] w_wr_addr_nxt;
  logic [ADDR_SIZE-1:0] w_rd_addr_nxt;
  logic [ADDR_SIZE-1:0] w_mem_addr_nxt;
  logic [7:0]           w_mem_wdata_nxt;
  logic                 w_mem_we_nxt;
  logic                 w_mem_re_nxt;
  logic [7:0]           w_tx_data_nxt;
  logic                 w_tx_valid_nxt;
  logic                 w_busy_nxt;
  logic                 w_cmd_drop_nxt;

  logic [1:0]           w_cmd;
  logic [7:0]           w_payload;
  logic [ADDR_SIZE-1:0] w_pl_addr;

  assign w_cmd     = rx_data[9:8];
  assign w_payload = rx_data[7:0];
  // Truncates for narrow RAMs, zero-extends for wide ones.
  assign w_pl_addr = ADDR_SIZE'(w_payload);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_drop  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_cmd_drop  <= w_cmd_drop_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_addr_nxt   = r_wr_addr;
    w_rd_addr_nxt   = r_rd_addr;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_we_nxt    = 1'b0;
    w_mem_re_nxt    = 1'b0;
    w_tx_data_nxt   = r_tx_data;
    w_tx_valid_nxt  = r_tx_valid;
    w_cmd_drop_nxt  = rx_valid && (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          case (w_cmd)
            CMD_WADDR: w_wr_addr_nxt = w_pl_addr;
            CMD_RADDR: w_rd_addr_nxt = w_pl_addr;
            CMD_WRITE: begin
              w_state_nxt     = WRITE;
              w_mem_we_nxt    = 1'b1;
              w_mem_addr_nxt  = r_wr_addr;
              w_mem_wdata_nxt = w_payload;
`ifdef SPI_RAM_CTRL_AUTOINC_EN
              w_wr_addr_nxt   = r_wr_addr + ADDR_SIZE'(1);
`else
              w_wr_addr_nxt   = r_wr_addr;
`endif
            end
            CMD_READ: begin
              w_state_nxt    = RD_REQ;
              w_mem_re_nxt   = 1'b1;
              w_mem_addr_nxt = r_rd_addr;
`ifdef SPI_RAM_CTRL_AUTOINC_EN
              w_rd_addr_nxt  = r_rd_addr + ADDR_SIZE'(1);
`else
              w_rd_addr_nxt  = r_rd_addr;
`endif
            end
            default: w_state_nxt = IDLE;
          endcase
        end
      end
      WRITE:   w_state_nxt = IDLE;
      RD_REQ:  w_state_nxt = RD_WAIT;
      // RAM data is valid in the cycle after the read strobe.
      RD_WAIT: begin
        w_tx_data_nxt  = mem_rdata;
        w_tx_valid_nxt = 1'b1;
        w_state_nxt    = RESP;
      end
      RESP: begin
        if (tx_ready) begin
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign busy      = r_busy;
  assign cmd_drop  = r_cmd_drop;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: directed scenarios plus randomized command stream against a transaction-level model.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       cmd_drop;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  int         ref_wr;
  int         ref_rd;
  logic [7:0] ref_mem [256];

  // RAM behavioural model
  logic [7:0] ram [256];
  bit         ram_ready = 1'b0;

  spi_ram_ctrl #(.ADDR_SIZE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .cmd_drop  (cmd_drop)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    return 8'(a) ^ 8'h4E;
  endfunction

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_re ? ram[mem_addr] : 8'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check("we_re_excl", 32'(mem_we & mem_re), 32'd0);
  endtask

  task automatic issue(input logic [9:0] w);
    rx_data  = w;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_we",    32'(mem_we),    32'd0);
    check("rst_re",    32'(mem_re),    32'd0);
    check("rst_txd",   32'(tx_data),   32'd0);
    check("rst_txv",   32'(tx_valid),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_drop",  32'(cmd_drop),  32'd0);
  endtask

  task automatic advance(inout int a);
`ifdef SPI_RAM_CTRL_AUTOINC_EN
    a = (a + 1) % 256;
`else
    a = a;
`endif
  endtask

  // Issue one command and follow it to completion; optionally inject a command while busy.
  task automatic do_cmd(input logic [9:0] w, input bit inj, input logic [9:0] injw, input int dly);
    logic [1:0] cmd;
    logic [7:0] pl;
    logic [7:0] exp;
    cmd = w[9:8];
    pl  = w[7:0];
    issue(w);
    check("c1_drop", 32'(cmd_drop), 32'd0);
    case (cmd)
      2'b00, 2'b10: begin
        if (cmd == 2'b00) ref_wr = int'(pl);
        else              ref_rd = int'(pl);
        check("addr_busy", 32'(busy),   32'd0);
        check("addr_we",   32'(mem_we), 32'd0);
        check("addr_re",   32'(mem_re), 32'd0);
      end
      2'b01: begin
        check("wr_we",    32'(mem_we),    32'd1);
        check("wr_addr",  32'(mem_addr),  32'(ref_wr));
        check("wr_wdata", 32'(mem_wdata), 32'(pl));
        check("wr_busy",  32'(busy),      32'd1);
        ref_mem[ref_wr] = pl;
        advance(ref_wr);
        if (inj) begin
          rx_data  = injw;
          rx_valid = 1'b1;
        end
        step();
        rx_valid = 1'b0;
        check("wr_done_we",   32'(mem_we),   32'd0);
        check("wr_done_busy", 32'(busy),     32'd0);
        check("wr_drop",      32'(cmd_drop), 32'(inj));
      end
      default: begin
        check("rd_re",   32'(mem_re),   32'd1);
        check("rd_addr", 32'(mem_addr), 32'(ref_rd));
        check("rd_busy", 32'(busy),     32'd1);
        exp = ref_mem[ref_rd];
        advance(ref_rd);
        tx_ready = 1'($urandom);
        step();
        check("rd_wait_re",  32'(mem_re),   32'd0);
        check("rd_wait_txv", 32'(tx_valid), 32'd0);
        if (inj) begin
          rx_data  = injw;
          rx_valid = 1'b1;
        end
        tx_ready = 1'($urandom);
        step();
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        check("resp_txv",  32'(tx_valid), 32'd1);
        check("resp_txd",  32'(tx_data),  32'(exp));
        check("resp_drop", 32'(cmd_drop), 32'(inj));
        for (int i = 0; i < dly; i++) begin
          step();
          check("hold_txv",  32'(tx_valid), 32'd1);
          check("hold_txd",  32'(tx_data),  32'(exp));
          check("hold_busy", 32'(busy),     32'd1);
        end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("rel_txv",  32'(tx_valid), 32'd0);
        check("rel_busy", 32'(busy),     32'd0);
      end
    endcase
  endtask

  initial begin
    logic [9:0] w;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b0;
    ref_wr   = 0;
    ref_rd   = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    repeat (3) step();
    check_reset_outputs();

    // First command in the first cycle out of reset; read returns 0x5C with a 4-cycle tx_ready delay
    rst_n = 1'b1;
    do_cmd(10'h212, 1'b0, 10'h000, 0);
    do_cmd(10'h300, 1'b0, 10'h000, 4);
    check("dir_rd_5c", 32'(tx_data), 32'h5C);

    do_cmd(10'h012, 1'b0, 10'h000, 0);
    do_cmd(10'h1A5, 1'b0, 10'h000, 0);

    // Address command dropped during RD_WAIT must not move wr_addr
    do_cmd(10'h000 | 10'(ref_wr), 1'b0, 10'h000, 0);
    do_cmd(10'h300, 1'b1, 10'h000, 1);
    do_cmd(10'h177, 1'b0, 10'h000, 0);

    // Write-address wrap behaviour
    do_cmd(10'h0FF, 1'b0, 10'h000, 0);
    do_cmd(10'h111, 1'b0, 10'h000, 0);
    do_cmd(10'h122, 1'b0, 10'h000, 0);

    for (int n = 0; n < 60; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tx_ready = 1'($urandom);
        step();
        check("idle_txv", 32'(tx_valid), 32'd0);
      end
      w = 10'($urandom);
      do_cmd(w, 1'($urandom), {2'($urandom_range(0, 2)) & 2'b10, 8'($urandom)},
             int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of a read
    issue(10'h300);
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    step();
    step();
    rst_n  = 1'b1;
    ref_wr = 0;
    ref_rd = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_txv",  32'(tx_valid), 32'd0);
      check("post_rst_busy", 32'(busy),     32'd0);
    end
    do_cmd(10'h13C, 1'b0, 10'h000, 0);
    do_cmd(10'h300, 1'b0, 10'h000, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
